fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: word-aligned address fetched first after reset.
REQ-002 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port stall  input  1  decode not ready; freezes fetch.
REQ-005 Port redirect  input  1  branch/jump taken; load redirect_pc.
REQ-006 Port redirect_pc  input  32  redirect target byte address.
REQ-007 Port pc  output  32  byte address to instruction memory (memory word index = pc[31:2], data returned one clock later).
REQ-008 Port ins_in  input  32  instruction word from instruction memory.
REQ-009 Port if_pc  output  32  address of instruction currently on if_ins.
REQ-010 Port if_ins  output  32  instruction to decode; combinational copy of ins_in.
REQ-011 Port if_valid  output  1  if_pc/if_ins hold a live instruction.
REQ-012 Port fetch_cnt  output  32  count of instructions accepted by decode.
REQ-013 Port fault  output  1  misaligned redirect detected (tied 0 when feature compiled out).

Function
REQ-014 FSM states: BOOT, RUN, FAULT; BOOT lasts exactly one clock after rst_n deasserts, then RUN.
REQ-015 BOOT: pc held at RESET_PC, if_valid stays 0, no counter change.
REQ-016 RUN, no stall, no redirect, each edge: if_pc<=pc, if_valid<=1, pc<=pc+4.
REQ-017 Latency: first if_valid=1 with if_pc=RESET_PC at 2nd rising edge after rst_n release.
REQ-018 RUN, stall=1, redirect=0: pc, if_pc, if_valid, fetch_cnt all hold (memory re-reads same pc, so if_ins stable).
REQ-019 Redirect (any stall value): pc<=redirect_pc with bits[1:0] forced 00, if_valid<=0 (in-flight fetch squashed); redirect has priority over stall.
REQ-020 After redirect, target instruction appears with if_valid=1 on the following edge (one bubble).
REQ-021 fetch_cnt increments by 1 on edges where if_valid=1, stall=0, redirect=0; wraps 32'hFFFF_FFFF->0.
REQ-022 pc arithmetic modulo 2^32: pc 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-023 Redirect during BOOT: takes effect as in REQ-019; state still moves to RUN.
REQ-024 FAULT state: pc, if_pc frozen, if_valid=0, fault=1, inputs ignored; exits only via reset.

Reset
REQ-025 rst_n=0 at an edge, from any state or mid-redirect/stall: pc<=RESET_PC, if_pc<=0, if_valid<=0, fetch_cnt<=0, fault<=0, state<=BOOT.
REQ-026 Reset has priority over redirect, stall and FAULT.

Configuration
REQ-027 Macro FETCH_ALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]!=00 moves FSM to FAULT next edge, pc<=redirect_pc with bits[1:0] forced 00, fault=1.
REQ-028 Macro undefined: FAULT unreachable, fault tied 0, misaligned targets silently masked per REQ-019.

Verification
REQ-029 Reset release, RESET_PC=0, stall=0 -> edge2: if_valid=1,if_pc=0; edge3: if_pc=4; fetch_cnt=1 after edge3.
REQ-030 Stall held 3 cycles while if_pc=8 -> pc=12, if_pc=8, fetch_cnt unchanged for all 3; resumes to if_pc=12 after release.
REQ-031 redirect=1,stall=1,redirect_pc=0x40 at if_pc=0x10 -> next edge if_valid=0,pc=0x40; following edge if_pc=0x40,if_valid=1.
REQ-032 Redirect to 0xFFFF_FFFC, run 2 cycles -> if_pc sequence 0xFFFF_FFFC then 0x0000_0000.
REQ-033 Macro defined, redirect_pc=0x42 -> fault=1,if_valid=0 sticky; rst_n low one edge -> fault=0,pc=RESET_PC; macro undefined -> pc=0x40, fault=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Purpose: single-issue instruction fetch front end (PC generation, IF register, accept counter).
// Latency: pc -> if_pc/if_valid one clock (memory returns data one clock after pc); first valid 2 clocks after reset release.
// Backpressure: stall freezes pc/if_pc/if_valid/fetch_cnt; redirect overrides stall and squashes the in-flight fetch.
//
// Ports:
//   clk          system clock, all state on rising edge
//   rst_n        synchronous active-low reset
//   stall        decode not ready, hold fetch
//   redirect     taken branch/jump, load redirect_pc
//   redirect_pc  redirect target byte address (bits [1:0] are masked)
//   pc           byte address to instruction memory
//   ins_in       instruction word returned by memory for the previous pc
//   if_pc        address of the instruction on if_ins
//   if_ins       instruction to decode (combinational copy of ins_in)
//   if_valid     if_pc/if_ins hold a live instruction
//   fetch_cnt    number of instructions accepted by decode (wraps)
//   fault        misaligned redirect detected (sticky until reset)
//
// Build option: define FETCH_ALIGN_CHECK_EN to trap misaligned redirect targets
// into the FAULT state; without it the low address bits are silently masked.

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    input  logic [31:0] ins_in,
    output logic [31:0] if_pc,
    output logic [31:0] if_ins,
    output logic        if_valid,
    output logic [31:0] fetch_cnt,
    output logic        fault
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] if_pc_nxt;
    logic        if_valid_nxt;
    logic [31:0] fetch_cnt_nxt;
    logic [31:0] target;
    logic        misaligned;

    // Word-align the redirect target; whole bus is consumed so no bits dangle.
    assign target = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = |redirect_pc[1:0];
    assign fault      = (state == FAULT);
`else
    assign misaligned = 1'b0;
    assign fault      = 1'b0;
`endif

    // Memory re-reads the held pc during a stall, so passing the data through
    // untouched keeps if_ins in step with if_pc.
    assign if_ins = ins_in;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= BOOT;
            pc        <= RESET_PC;
            if_pc     <= 32'h0000_0000;
            if_valid  <= 1'b0;
            fetch_cnt <= 32'h0000_0000;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            if_pc     <= if_pc_nxt;
            if_valid  <= if_valid_nxt;
            fetch_cnt <= fetch_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        if_pc_nxt     = if_pc;
        if_valid_nxt  = if_valid;
        fetch_cnt_nxt = fetch_cnt;

        case (state)
            BOOT: begin
                // Memory has not yet seen RESET_PC, so nothing is delivered here.
                state_nxt = RUN;
                if (redirect) begin
                    pc_nxt       = target;
                    if_valid_nxt = 1'b0;
                    if (misaligned) begin
                        state_nxt = FAULT;
                    end
                end
            end

            RUN: begin
                if (redirect) begin
                    // Data arriving next clock belongs to the old path: squash it.
                    pc_nxt       = target;
                    if_valid_nxt = 1'b0;
                    if (misaligned) begin
                        state_nxt = FAULT;
                    end
                end else if (!stall) begin
                    if (if_valid) begin
                        fetch_cnt_nxt = fetch_cnt + 32'd1;
                    end
                    if_pc_nxt    = pc;
                    if_valid_nxt = 1'b1;
                    pc_nxt       = pc + 32'd4;
                end
            end

            FAULT: begin
                if_valid_nxt = 1'b0;
            end

            default: begin
                state_nxt    = BOOT;
                if_valid_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Purpose: directed bench for fetch_unit with a per-cycle reference model and literal checkpoints.
// Latency: checks sampled 1 time unit after each rising edge (model) and on falling edges (directed).
// Backpressure: stall/redirect driven on falling edges from the stimulus process.

module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] INS_KEY  = 32'h1357_9BDF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] pc;
    logic [31:0] ins_in = 32'h0;
    logic [31:0] if_pc;
    logic [31:0] if_ins;
    logic        if_valid;
    logic [31:0] fetch_cnt;
    logic        fault;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (pc),
        .ins_in      (ins_in),
        .if_pc       (if_pc),
        .if_ins      (if_ins),
        .if_valid    (if_valid),
        .fetch_cnt   (fetch_cnt),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    // Instruction memory: synchronous read, word index pc[31:2], content derived from address.
    always @(posedge clk) begin
        ins_in <= {pc[31:2], 2'b00} ^ INS_KEY;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Fetch stream view: 'next_addr' is the address memory is being asked for,
    // 'shown_addr/shown' is what decode currently sees, 'accepted' counts hand-offs.
    bit          m_live = 0;
    bit          m_boot;
    bit          m_trapped;
    logic [31:0] m_next_addr;
    logic [31:0] m_shown_addr;
    bit          m_shown;
    logic [31:0] m_accepted;

    always @(posedge clk) begin
        bit          s_rst_n, s_stall, s_redir;
        logic [31:0] s_target;
        s_rst_n  = rst_n;
        s_stall  = stall;
        s_redir  = redirect;
        s_target = redirect_pc;

        if (!s_rst_n) begin
            m_live       = 1;
            m_boot       = 1;
            m_trapped    = 0;
            m_next_addr  = RESET_PC;
            m_shown_addr = 32'h0;
            m_shown      = 0;
            m_accepted   = 32'h0;
        end else if (m_live && !m_trapped) begin
            if (s_redir) begin
                m_next_addr = {s_target[31:2], 2'b00};
                m_shown     = 0;
                m_boot      = 0;
`ifdef FETCH_ALIGN_CHECK_EN
                if (s_target[1:0] != 2'b00) m_trapped = 1;
`endif
            end else if (m_boot) begin
                m_boot = 0;
            end else if (!s_stall) begin
                m_accepted   = m_accepted + (m_shown ? 32'd1 : 32'd0);
                m_shown_addr = m_next_addr;
                m_shown      = 1;
                m_next_addr  = m_next_addr + 32'd4;
            end
        end

        #1;
        if (m_live) begin
            check("model_pc",        pc,        m_next_addr);
            check("model_if_pc",     if_pc,     m_shown_addr);
            check("model_if_valid",  {31'b0, if_valid}, {31'b0, m_shown});
            check("model_fetch_cnt", fetch_cnt, m_accepted);
            check("model_fault",     {31'b0, fault},    {31'b0, m_trapped});
            check("model_if_ins",    if_ins,    ins_in);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        // Reset held two edges.
        tick(2);
        check("rst_pc",        pc,        RESET_PC);
        check("rst_if_pc",     if_pc,     32'h0);
        check("rst_if_valid",  {31'b0, if_valid}, 32'h0);
        check("rst_fetch_cnt", fetch_cnt, 32'h0);
        check("rst_fault",     {31'b0, fault},    32'h0);

        // Release: edge1 BOOT, edge2 first valid, edge3 if_pc=4 and one accepted.
        rst_n = 1'b1;
        tick(1);
        check("boot_if_valid", {31'b0, if_valid}, 32'h0);
        check("boot_pc",       pc,        32'h0);
        tick(1);
        check("e2_if_valid",   {31'b0, if_valid}, 32'h1);
        check("e2_if_pc",      if_pc,     32'h0);
        check("e2_cnt",        fetch_cnt, 32'h0);
        tick(1);
        check("e3_if_pc",      if_pc,     32'h4);
        check("e3_cnt",        fetch_cnt, 32'h1);
        tick(1);
        check("e4_if_pc",      if_pc,     32'h8);
        check("e4_pc",         pc,        32'hC);

        // Stall three cycles with if_pc=8.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("stall_pc",    pc,        32'hC);
            check("stall_if_pc", if_pc,     32'h8);
            check("stall_cnt",   fetch_cnt, 32'h2);
        end
        stall = 1'b0;
        tick(1);
        check("resume_if_pc", if_pc,     32'hC);
        check("resume_cnt",   fetch_cnt, 32'h3);
        tick(1);
        check("pre_redir_if_pc", if_pc, 32'h10);

        // Redirect together with stall at if_pc=0x10.
        redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h40;
        tick(1);
        check("redir_if_valid", {31'b0, if_valid}, 32'h0);
        check("redir_pc",       pc,        32'h40);
        redirect = 1'b0; stall = 1'b0;
        tick(1);
        check("tgt_if_pc",    if_pc,     32'h40);
        check("tgt_if_valid", {31'b0, if_valid}, 32'h1);
        check("tgt_if_ins",   if_ins,    32'h40 ^ INS_KEY);
        check("tgt_cnt",      fetch_cnt, 32'h4);

        // Address wrap.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick(1);
        redirect = 1'b0;
        tick(1);
        check("wrap_if_pc0", if_pc, 32'hFFFF_FFFC);
        check("wrap_pc0",    pc,    32'h0);
        tick(1);
        check("wrap_if_pc1", if_pc, 32'h0);
        check("wrap_cnt",    fetch_cnt, 32'h5);

        // Reset while redirect and stall asserted, then redirect during BOOT.
        rst_n = 1'b0; redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h200;
        tick(1);
        check("rst_redir_pc",  pc,        RESET_PC);
        check("rst_redir_cnt", fetch_cnt, 32'h0);
        rst_n = 1'b1; stall = 1'b0; redirect_pc = 32'h100;
        tick(1);
        check("bootredir_pc", pc, 32'h100);
        check("bootredir_if_valid", {31'b0, if_valid}, 32'h0);
        redirect = 1'b0;
        tick(1);
        check("bootredir_if_pc", if_pc, 32'h100);
        check("bootredir_vld",   {31'b0, if_valid}, 32'h1);
        tick(2);

        // Misaligned redirect.
        redirect = 1'b1; redirect_pc = 32'h42;
        tick(1);
        redirect = 1'b0;
        check("mis_pc", pc, 32'h40);
        check("mis_if_valid", {31'b0, if_valid}, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        check("mis_fault", {31'b0, fault}, 32'h1);
        redirect = 1'b1; redirect_pc = 32'h80;
        tick(3);
        redirect = 1'b0;
        check("mis_sticky_fault", {31'b0, fault}, 32'h1);
        check("mis_sticky_pc",    pc, 32'h40);
        check("mis_sticky_vld",   {31'b0, if_valid}, 32'h0);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("mis_rst_fault", {31'b0, fault}, 32'h0);
        check("mis_rst_pc",    pc, RESET_PC);
        tick(3);
`else
        check("mis_fault", {31'b0, fault}, 32'h0);
        tick(1);
        check("mis_if_pc", if_pc, 32'h40);
        check("mis_vld",   {31'b0, if_valid}, 32'h1);
        tick(2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
